// File: rtl/estagio_busca.sv
`default_nettype none
// ============================================================================
// Module      : estagio_busca
// Description : Instruction fetch stage. Owns the PC, issues 1-cycle-latency
//               imem reads and buffers returned words with their pc+4.
//               Optional fetch counter when CONT_BUSCA_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module estagio_busca #(
  parameter int              LARG      = 32,
  parameter logic [LARG-1:0] PC_RESET  = '0,
  parameter int              PROF_FILA = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [LARG-1:0] imem_addr,
  input  logic [LARG-1:0] imem_data,
  input  logic            desvio,
  input  logic [LARG-1:0] desvio_alvo,
  input  logic            parar,
  output logic [LARG-1:0] instr_out,
  output logic [LARG-1:0] pc4_out,
  output logic            valido_out
`ifdef CONT_BUSCA_EN
  ,
  output logic [31:0]     cont_busca
`endif
);

  localparam int PW = $clog2(PROF_FILA);
  localparam int CW = PW + 1;

  logic [LARG-1:0] r_pc;
  logic [LARG-1:0] r_pc4_voo;
  logic            r_em_voo;
  logic            r_epoca;
  logic            r_epoca_voo;
  logic [CW-1:0]   r_ocup;
  logic [PW-1:0]   r_rd;
  logic [PW-1:0]   r_wr;
  logic [LARG-1:0] r_mem_instr [PROF_FILA];
  logic [LARG-1:0] r_mem_pc4   [PROF_FILA];

  logic            w_pop;
  logic            w_push;
  logic [CW:0]     w_uso;

  assign valido_out = (r_ocup != '0);
  assign w_pop      = valido_out && !parar;
  assign w_push     = r_em_voo && (r_epoca_voo == r_epoca);

  // A slot vacated by this cycle's pop counts as free, which is what keeps
  // the stream at one instruction per cycle with a two-entry buffer.
  assign w_uso     = (CW+1)'(r_ocup) + (CW+1)'(r_em_voo) - (CW+1)'(w_pop);
  assign imem_req  = !rst && !desvio && (w_uso < (CW+1)'(PROF_FILA));
  assign imem_addr = r_pc;

  assign instr_out = valido_out ? r_mem_instr[r_rd] : '0;
  assign pc4_out   = valido_out ? r_mem_pc4[r_rd]   : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= PC_RESET;
      r_pc4_voo   <= '0;
      r_em_voo    <= 1'b0;
      r_epoca     <= 1'b0;
      r_epoca_voo <= 1'b0;
      r_ocup      <= '0;
      r_rd        <= '0;
      r_wr        <= '0;
    end else if (desvio) begin
      r_pc     <= desvio_alvo & ~LARG'(3);
      r_em_voo <= 1'b0;
      r_epoca  <= ~r_epoca;
      r_ocup   <= '0;
      r_rd     <= '0;
      r_wr     <= '0;
    end else begin
      r_em_voo    <= imem_req;
      r_epoca_voo <= r_epoca;
      if (imem_req) begin
        r_pc      <= r_pc + LARG'(4);
        r_pc4_voo <= r_pc + LARG'(4);
      end
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_ocup <= r_ocup + CW'(w_push) - CW'(w_pop);
    end
  end

  // Buffer storage needs no reset: outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wr] <= imem_data;
      r_mem_pc4[r_wr]   <= r_pc4_voo;
    end
  end

`ifdef CONT_BUSCA_EN
  logic [31:0] r_cont;

  always_ff @(posedge clk) begin
    if (rst)        r_cont <= '0;
    else if (w_pop) r_cont <= r_cont + 32'd1;
  end

  assign cont_busca = r_cont;
`endif

endmodule
`default_nettype wire
